instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
Byte-addressed instruction store for the 24-bit single-cycle CPU. The fetch stage drives the program counter (PC) and receives a 24-bit instruction combinationally in the same cycle. A synchronous byte-wide programming port loads the program image. An active-low synchronous reset clears the whole store to the NOP encoding 0x00.

Parameters:
MEM_BYTES, 128, number of byte cells. Legal byte addresses are 0..MEM_BYTES-1. Must be at least 3.

Ports:
Clock  input  1  single system clock; all state updates occur on its rising edge
Reset  input  1  synchronous, active-low; clears memory when sampled low at a rising edge
PC  input  24  byte address of the instruction to fetch
Instruction  output  24  fetched instruction word
Fault  output  1  high when the fetch touches any byte outside the memory
Prog_WE  input  1  byte write enable for the programming port
Prog_Addr  input  24  byte address for the programming write
Prog_Data  input  8  byte value to write

Behaviour:
- Storage: MEM_BYTES cells of 8 bits each, held in a register array.
- Fetch is purely combinational, with zero clock latency:
  - Instruction = {mem[PC], mem[PC+1], mem[PC+2]}, big-endian.
  - mem[PC] supplies Instruction[23:16]; mem[PC+2] supplies Instruction[7:0].
- Any PC value is allowed. There is no alignment requirement, so instructions may start at any byte.
- Address arithmetic for PC+1 and PC+2 uses 25 bits, so it never wraps around.
- Any byte whose address is at or beyond MEM_BYTES reads as 0x00.
- Fault = 1 when PC+2 >= MEM_BYTES (at least one byte is out of range); otherwise Fault = 0. Fault is combinational.
- Reset:
  - On a rising edge with Reset = 0, every cell becomes 0x00.
  - Prog_WE is ignored in that cycle, because reset has priority.
  - After reset, for any PC, Instruction = 0x000000.
- Programming write:
  - On a rising edge with Reset = 1 and Prog_WE = 1 and Prog_Addr < MEM_BYTES, mem[Prog_Addr] <= Prog_Data.
  - If Prog_Addr >= MEM_BYTES the write is silently dropped and no cell changes.
- Read-during-write: while a write is pending, Instruction shows the old byte. The new byte appears right after the rising edge, with no bypass.
- Only one byte can be written per cycle.
- Before the first reset, cell contents are undefined. The bench must apply reset first.
- No other outputs are registered. Instruction and Fault depend only on PC and the current memory state.

Test Plan:
1. Hold Reset = 0 for 2 edges, then set PC = 16 -> Instruction = 0x000000, Fault = 0.
2. Reset released. Write 0x12 to 16, 0x34 to 17, 0x56 to 18, then PC = 16 -> Instruction = 0x123456. PC = 17 -> Instruction = 0x345600.
3. With MEM_BYTES = 128: PC = 125 -> Fault = 0. PC = 126 -> Fault = 1, Instruction[7:0] = 0x00. PC = 0xFFFFFF -> Fault = 1, Instruction = 0x000000.
4. Set Prog_WE = 1, Prog_Addr = 200, Prog_Data = 0xFF, and clock an edge -> no cell changes, and reads at 0..127 are unchanged.
5. With PC = 16 showing 0x123456, write 0xAB to address 16 -> before the edge Instruction = 0x123456; after the edge Instruction = 0xAB3456.
6. Assert Reset = 0 together with Prog_WE = 1 (address 16, data 0x77) for one edge -> the reset wins, and PC = 16 reads Instruction = 0x000000.

Source files
------------

// File: rtl/instruction_memory.sv
// instruction_memory: byte-addressed instruction store with combinational 24-bit big-endian fetch
// ports: clk, rst_n (sync, active-low, clears store), pc -> instruction/fault (combinational),
//        prog_we/prog_addr/prog_data (synchronous byte write, out-of-range writes dropped)
module instruction_memory #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pc,
  output logic [23:0] instruction,
  output logic        fault,
  input  logic        prog_we,
  input  logic [23:0] prog_addr,
  input  logic [7:0]  prog_data
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [7:0] mem [MEM_BYTES];
  logic [24:0] a0, a1, a2;
  logic [7:0] b0, b1, b2;
  always_comb begin
    a0 = {1'b0, pc};
    a1 = a0 + 25'd1;
    a2 = a0 + 25'd2;
    b0 = a0 < 25'(MEM_BYTES) ? mem[a0[AW-1:0]] : 8'h00;
    b1 = a1 < 25'(MEM_BYTES) ? mem[a1[AW-1:0]] : 8'h00;
    b2 = a2 < 25'(MEM_BYTES) ? mem[a2[AW-1:0]] : 8'h00;
    instruction = {b0, b1, b2};
    fault = a2 >= 25'(MEM_BYTES);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (prog_we && prog_addr < 24'(MEM_BYTES)) begin
      mem[prog_addr[AW-1:0]] <= prog_data;
    end
  end
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: scoreboard bench for instruction_memory
module tb_instruction_memory;
  localparam int MB = 128;
  logic clk = 1'b0;
  logic rst_n, prog_we, fault;
  logic [23:0] pc, instruction, prog_addr;
  logic [7:0] prog_data;
  logic [7:0] m [MB];
  int checks = 0;
  int failures = 0;
  typedef struct { logic [23:0] ins; logic f; } exp_t;
  exp_t q [$];

  instruction_memory #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction), .fault(fault),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [24:0] a);
    return a < 25'(MB) ? m[a[6:0]] : 8'h00;
  endfunction

  function automatic exp_t model(input logic [23:0] p);
    exp_t e;
    logic [24:0] a;
    a = {1'b0, p};
    e.ins = {mb(a), mb(a + 25'd1), mb(a + 25'd2)};
    e.f = (a + 25'd2) >= 25'(MB);
    return e;
  endfunction

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_ins"}, {8'h0, instruction}, {8'h0, e.ins});
      chk({tag, "_fault"}, {31'h0, fault}, {31'h0, e.f});
    end
  endtask

  task automatic fetch(input logic [23:0] p, input string tag);
    @(negedge clk);
    pc = p;
    q.push_back(model(p));
    #1 compare(tag);
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    if (rst_n && a < 24'(MB)) m[a[6:0]] = d;
    #1 prog_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    pc = '0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < MB; i++) m[i] = 8'h00;
    fetch(24'd16, "rst16");
    chk("rst16_const", {8'h0, instruction}, 32'h0);
    fetch(24'd127, "rst127");
    @(negedge clk);
    rst_n = 1'b1;
    wr(24'd16, 8'h12);
    wr(24'd17, 8'h34);
    wr(24'd18, 8'h56);
    fetch(24'd16, "pc16");
    chk("pc16_const", {8'h0, instruction}, 32'h123456);
    fetch(24'd17, "pc17");
    chk("pc17_const", {8'h0, instruction}, 32'h345600);
    wr(24'd125, 8'hA1);
    wr(24'd126, 8'hA2);
    wr(24'd127, 8'hA3);
    wr(24'd0, 8'hC0);
    wr(24'd72, 8'h5A);
    for (int i = 0; i < 6; i++) wr(24'($urandom_range(20, 120)), 8'($urandom_range(1, 255)));
    fetch(24'd125, "pc125");
    chk("pc125_const", {7'h0, fault, instruction}, {7'h0, 1'b0, 24'hA1A2A3});
    fetch(24'd126, "pc126");
    chk("pc126_const", {7'h0, fault, instruction}, {7'h0, 1'b1, 24'hA2A300});
    fetch(24'd127, "pc127");
    fetch(24'd128, "pc128");
    fetch(24'hFFFFFF, "pcmax");
    chk("pcmax_const", {7'h0, fault, instruction}, {7'h0, 1'b1, 24'h000000});
    fetch(24'hFFFFFE, "pcmax1");
    wr(24'd200, 8'hFF);
    wr(24'd144, 8'hEE);
    wr(24'h800010, 8'hDD);
    for (int i = 0; i < MB; i++) fetch(24'(i), "sweep");
    @(negedge clk);
    pc = 24'd16;
    prog_we = 1'b1;
    prog_addr = 24'd16;
    prog_data = 8'hAB;
    q.push_back(model(24'd16));
    #1 compare("rdw_before");
    chk("rdw_before_const", {8'h0, instruction}, 32'h123456);
    @(posedge clk);
    m[16] = 8'hAB;
    #1 prog_we = 1'b0;
    fetch(24'd16, "rdw_after");
    chk("rdw_after_const", {8'h0, instruction}, 32'hAB3456);
    @(negedge clk);
    rst_n = 1'b0;
    prog_we = 1'b1;
    prog_addr = 24'd16;
    prog_data = 8'h77;
    @(posedge clk);
    for (int i = 0; i < MB; i++) m[i] = 8'h00;
    #1;
    rst_n = 1'b1;
    prog_we = 1'b0;
    fetch(24'd16, "rstwe16");
    chk("rstwe16_const", {8'h0, instruction}, 32'h0);
    fetch(24'd125, "rstwe125");
    fetch(24'd0, "rstwe0");
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
